// File: rtl/user_au_stream_arbiter_if.sv
// Bundle of the per-channel source, shared filter and per-channel result handshakes
// around the stream arbiter. slave = arbiter view, master = environment view.
interface user_au_stream_arbiter_if #(
    parameter int NumCh     = 2,
    parameter int DataWidth = 32
);
    logic [NumCh*DataWidth-1:0] ch_data_i;
    logic [NumCh-1:0]           ch_valid_i;
    logic [NumCh-1:0]           ch_ready_o;
    logic [DataWidth-1:0]       flt_data_o;
    logic                       flt_valid_o;
    logic                       flt_ready_i;
    logic [DataWidth-1:0]       flt_data_i;
    logic                       flt_valid_i;
    logic                       flt_ready_o;
    logic [DataWidth-1:0]       res_data_o;
    logic [NumCh-1:0]           res_valid_o;
    logic [NumCh-1:0]           res_ready_i;

    modport slave (
        input  ch_data_i, ch_valid_i, flt_ready_i, flt_data_i, flt_valid_i, res_ready_i,
        output ch_ready_o, flt_data_o, flt_valid_o, flt_ready_o, res_data_o, res_valid_o
    );

    modport master (
        output ch_data_i, ch_valid_i, flt_ready_i, flt_data_i, flt_valid_i, res_ready_i,
        input  ch_ready_o, flt_data_o, flt_valid_o, flt_ready_o, res_data_o, res_valid_o
    );
endinterface

// File: rtl/user_au_stream_arbiter.sv
// Round-robin arbiter sharing one filter datapath between NumCh sample streams;
// a tag FIFO remembers the issuing channel so in-order results are routed back.
module user_au_stream_arbiter #(
    parameter int NumCh          = 2,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    user_au_stream_arbiter_if.slave bus,
    output logic                    busy_o,
    output logic                    err_o
);
    localparam int TagW = (NumCh > 1) ? $clog2(NumCh) : 1;
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    typedef logic [TagW-1:0] tag_t;
    typedef enum logic {IDLE, LOCKED} state_e;

    state_e          state_q, state_d;
    tag_t            rr_q, rr_d;
    tag_t            lock_q, lock_d;
    tag_t            tags_q [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            err_q;

    logic fifo_empty, fifo_full;
    logic push, pop;
    logic granting, grant_valid;
    tag_t grant, head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PtrW+1)'(MaxOutstanding));
    assign head       = tags_q[rd_ptr_q];
    assign busy_o     = !fifo_empty;
    assign err_o      = err_q;

    // Return path: forward the filter result to the channel tagged at the FIFO head.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        pop             = 1'b0;
        bus.res_valid_o = '0;
        bus.res_data_o  = '0;
        bus.flt_ready_o = 1'b0;
        if (rst_ni) begin
            bus.res_data_o = bus.flt_data_i;
            if (!fifo_empty) begin
                bus.res_valid_o = NumCh'(bus.flt_valid_i) << head;
                bus.flt_ready_o = bus.res_ready_i[head];
                pop             = bus.flt_valid_i & bus.res_ready_i[head];
            end else begin
                bus.flt_ready_o = bus.flt_valid_i;
            end
        end
    end

    // Issue path: round-robin pick in IDLE, grant held on the latched channel in LOCKED.
    always_comb begin
        state_d         = state_q;
        rr_d            = rr_q;
        lock_d          = lock_q;
        grant           = lock_q;
        granting        = 1'b0;
        grant_valid     = 1'b0;
        push            = 1'b0;
        bus.flt_valid_o = 1'b0;
        bus.flt_data_o  = '0;
        bus.ch_ready_o  = '0;

        case (state_q)
            IDLE: begin
                if (rst_ni && en_i && (!fifo_full || pop)) begin
                    for (int i = 0; i < NumCh; i++) begin
                        if (!granting && bus.ch_valid_i[(int'(rr_q) + i) % NumCh]) begin
                            granting    = 1'b1;
                            grant_valid = 1'b1;
                            grant       = tag_t'((int'(rr_q) + i) % NumCh);
                        end
                    end
                end
            end
            LOCKED: begin
                granting    = rst_ni;
                grant_valid = rst_ni & bus.ch_valid_i[lock_q];
            end
            default: state_d = IDLE;
        endcase

        if (granting) begin
            bus.flt_valid_o       = grant_valid;
            bus.flt_data_o        = bus.ch_data_i[grant*DataWidth +: DataWidth];
            bus.ch_ready_o[grant] = bus.flt_ready_i;
            push                  = grant_valid & bus.flt_ready_i;
            if (push) begin
                rr_d    = tag_t'((int'(grant) + 1) % NumCh);
                state_d = IDLE;
            end else begin
                lock_d  = grant;
                state_d = LOCKED;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            lock_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
            if (fifo_empty && bus.flt_valid_i) err_q <= 1'b1;
        end
    end

    // NOTE: tag storage has no reset; entries are only read while the count says they are valid.
    always_ff @(posedge clk_i) begin
        if (push) tags_q[wr_ptr_q] <= grant;
    end
endmodule

// File: tb/tb_user_au_stream_arbiter.sv
// Directed bench for user_au_stream_arbiter: a queue-based model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_user_au_stream_arbiter;
    localparam int NCH  = 2;
    localparam int DW   = 32;
    localparam int MAXO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic busy, err;

    user_au_stream_arbiter_if #(.NumCh(NCH), .DataWidth(DW)) bus();

    user_au_stream_arbiter #(.NumCh(NCH), .DataWidth(DW), .MaxOutstanding(MAXO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (en),
        .bus    (bus),
        .busy_o (busy),
        .err_o  (err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: queue of channel tags in flight, round-robin start, lock flag, sticky error.
    typedef struct packed {
        logic           fv;
        logic [DW-1:0]  fd;
        logic [NCH-1:0] chr;
        logic           fro;
        logic [NCH-1:0] rv;
        logic           push;
        logic           pop;
        int             g;
    } exp_t;

    int   m_q[$];
    int   m_rr     = 0;
    bit   m_locked = 1'b0;
    int   m_lock   = 0;
    bit   m_err    = 1'b0;
    exp_t cmp_e, upd_e;

    function automatic exp_t predict();
        exp_t e;
        e = '0;
        if (m_q.size() > 0) begin
            e.rv  = bus.flt_valid_i ? (NCH'(1) << m_q[0]) : '0;
            e.fro = bus.res_ready_i[m_q[0]];
            e.pop = bus.flt_valid_i && bus.res_ready_i[m_q[0]];
        end else begin
            e.fro = bus.flt_valid_i;
        end
        if (m_locked) begin
            e.g          = m_lock;
            e.fv         = bus.ch_valid_i[m_lock];
            e.chr[m_lock] = bus.flt_ready_i;
        end else if (en && (m_q.size() < MAXO || e.pop)) begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_rr + k) % NCH;
                if (!e.fv && bus.ch_valid_i[c]) begin
                    e.fv = 1'b1;
                    e.g  = c;
                end
            end
            if (e.fv) e.chr[e.g] = bus.flt_ready_i;
        end
        e.fd   = bus.ch_data_i[e.g*DW +: DW];
        e.push = e.fv && bus.flt_ready_i;
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_rr     = 0;
            m_locked = 1'b0;
            m_lock   = 0;
            m_err    = 1'b0;
        end else begin
            upd_e = predict();
            if (m_q.size() == 0 && bus.flt_valid_i) m_err = 1'b1;
            if (upd_e.pop) void'(m_q.pop_front());
            if (upd_e.push) begin
                m_q.push_back(upd_e.g);
                m_rr     = (upd_e.g + 1) % NCH;
                m_locked = 1'b0;
            end else if (!m_locked && upd_e.fv) begin
                m_locked = 1'b1;
                m_lock   = upd_e.g;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            cmp_e = predict();
            check("m_flt_valid_o", bus.flt_valid_o, cmp_e.fv);
            if (cmp_e.fv) check("m_flt_data_o", bus.flt_data_o, cmp_e.fd);
            check("m_ch_ready_o", bus.ch_ready_o, cmp_e.chr);
            check("m_flt_ready_o", bus.flt_ready_o, cmp_e.fro);
            check("m_res_valid_o", bus.res_valid_o, cmp_e.rv);
            if (|cmp_e.rv) check("m_res_data_o", bus.res_data_o, bus.flt_data_i);
            check("m_busy_o", busy, m_q.size() != 0);
            check("m_err_o", err, m_err);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flt_valid_o"}, bus.flt_valid_o, 0);
        check({tag, "_flt_data_o"}, bus.flt_data_o, 0);
        check({tag, "_ch_ready_o"}, bus.ch_ready_o, 0);
        check({tag, "_flt_ready_o"}, bus.flt_ready_o, 0);
        check({tag, "_res_valid_o"}, bus.res_valid_o, 0);
        check({tag, "_res_data_o"}, bus.res_data_o, 0);
        check({tag, "_busy_o"}, busy, 0);
        check({tag, "_err_o"}, err, 0);
    endtask

    logic [DW-1:0]  fair_exp [4] = '{32'h0000_00B1, 32'h0000_00A0, 32'h0000_00B1, 32'h0000_00A0};
    logic [NCH-1:0] fair_ret [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with live-looking inputs: every output must still read zero.
        bus.ch_data_i   = {32'h0000_0BBB, 32'h0000_0AAA};
        bus.ch_valid_i  = 2'b11;
        bus.flt_ready_i = 1'b1;
        bus.flt_data_i  = 32'h0000_0DDD;
        bus.flt_valid_i = 1'b1;
        bus.res_ready_i = 2'b11;
        en              = 1'b1;
        #12;
        check_all_zero("rst");
        bus.ch_valid_i  = '0;
        bus.flt_ready_i = 1'b0;
        bus.flt_valid_i = 1'b0;
        bus.res_ready_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        next();

        // Single channel: issue on ch0, result returns three cycles later.
        bus.ch_data_i   = {32'h0, 32'h0000_1111};
        bus.ch_valid_i  = 2'b01;
        bus.flt_ready_i = 1'b1;
        settle();
        check("t1_flt_valid_o", bus.flt_valid_o, 1);
        check("t1_flt_data_o", bus.flt_data_o, 32'h0000_1111);
        check("t1_ch_ready_o", bus.ch_ready_o, 2'b01);
        next();
        bus.ch_valid_i  = '0;
        bus.flt_ready_i = 1'b0;
        settle();
        check("t1_busy_on", busy, 1);
        next();
        next();
        bus.flt_valid_i = 1'b1;
        bus.flt_data_i  = 32'h0000_2222;
        bus.res_ready_i = 2'b01;
        settle();
        check("t1_res_valid_o", bus.res_valid_o, 2'b01);
        check("t1_res_data_o", bus.res_data_o, 32'h0000_2222);
        next();
        bus.flt_valid_i = 1'b0;
        bus.res_ready_i = '0;
        settle();
        check("t1_busy_off", busy, 0);

        // Fairness: pointer sits at ch1 after the ch0 grant, so grants go 1,0,1,0.
        next();
        bus.ch_data_i   = {32'h0000_00B1, 32'h0000_00A0};
        bus.ch_valid_i  = 2'b11;
        bus.flt_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("t2_grant_data", bus.flt_data_o, fair_exp[i]);
            next();
        end
        bus.ch_valid_i  = '0;
        bus.flt_ready_i = 1'b0;
        bus.flt_valid_i = 1'b1;
        bus.res_ready_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            bus.flt_data_i = 32'h300 + i;
            settle();
            check("t2_res_valid_o", bus.res_valid_o, fair_ret[i]);
            next();
        end
        bus.flt_valid_i = 1'b0;
        bus.res_ready_i = '0;

        // Lock: ch1 held while filter stalls, even though ch0 is requesting.
        bus.ch_data_i   = {32'h0000_00C1, 32'h0000_00C0};
        bus.ch_valid_i  = 2'b10;
        bus.flt_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("t3_lock_data", bus.flt_data_o, 32'h0000_00C1);
            check("t3_lock_ready", bus.ch_ready_o, 2'b00);
            next();
            bus.ch_valid_i = 2'b11;
        end
        bus.flt_ready_i = 1'b1;
        settle();
        check("t3_release_ready", bus.ch_ready_o, 2'b10);
        next();
        bus.ch_valid_i = 2'b01;
        settle();
        check("t3_next_grant", bus.flt_data_o, 32'h0000_00C0);
        next();
        bus.ch_valid_i  = '0;
        bus.flt_ready_i = 1'b0;

        // Return backpressure: FIFO holds [1,0]; pop ch1, then stall on ch0 head.
        bus.flt_valid_i = 1'b1;
        bus.flt_data_i  = 32'h401;
        bus.res_ready_i = 2'b10;
        settle();
        check("t4_first_res", bus.res_valid_o, 2'b10);
        next();
        bus.flt_data_i  = 32'h402;
        bus.res_ready_i = 2'b00;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("t4_stall_ready", bus.flt_ready_o, 0);
            check("t4_stall_busy", busy, 1);
            next();
        end
        bus.res_ready_i = 2'b01;
        settle();
        check("t4_release_ready", bus.flt_ready_o, 1);
        next();
        bus.flt_valid_i = 1'b0;
        bus.res_ready_i = '0;
        settle();
        check("t4_busy_off", busy, 0);

        // Full FIFO: four issues, fifth stalls until a same-cycle pop frees a slot.
        next();
        bus.ch_data_i   = {32'h0000_00D1, 32'h0000_00D0};
        bus.ch_valid_i  = 2'b11;
        bus.flt_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) next();
        settle();
        check("t5_full_stall", bus.flt_valid_o, 0);
        check("t5_full_ready", bus.ch_ready_o, 2'b00);
        next();
        bus.flt_valid_i = 1'b1;
        bus.flt_data_i  = 32'h500;
        bus.res_ready_i = 2'b11;
        settle();
        check("t5_pushpop_valid", bus.flt_valid_o, 1);
        check("t5_pushpop_data", bus.flt_data_o, 32'h0000_00D1);
        next();
        bus.flt_valid_i = 1'b0;
        settle();
        check("t5_still_full", bus.flt_valid_o, 0);
        next();
        bus.ch_valid_i  = '0;
        bus.flt_ready_i = 1'b0;
        bus.flt_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) next();
        bus.flt_valid_i = 1'b0;
        bus.res_ready_i = '0;
        settle();
        check("t5_drained", busy, 0);

        // Spurious result with an empty FIFO: dropped, error sticks.
        next();
        bus.flt_valid_i = 1'b1;
        settle();
        check("t6_drop_ready", bus.flt_ready_o, 1);
        check("t6_drop_valid", bus.res_valid_o, 2'b00);
        next();
        bus.flt_valid_i = 1'b0;
        settle();
        check("t6_err_set", err, 1);
        next();
        settle();
        check("t6_err_sticky", err, 1);

        // Grants disabled: pending valids are ignored.
        next();
        en              = 1'b0;
        bus.ch_valid_i  = 2'b11;
        bus.flt_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t7_no_grant", bus.flt_valid_o, 0);
            next();
        end

        // Asynchronous reset while LOCKED.
        en              = 1'b1;
        bus.ch_valid_i  = 2'b01;
        bus.flt_ready_i = 1'b0;
        settle();
        check("t8_granted", bus.flt_valid_o, 1);
        next();
        settle();
        check("t8_locked", bus.flt_valid_o, 1);
        bus.ch_valid_i  = 2'b11;
        bus.flt_valid_i = 1'b1;
        bus.res_ready_i = 2'b11;
        rst_n           = 1'b0;
        #1;
        check_all_zero("t8_rst");
        bus.ch_valid_i  = '0;
        bus.flt_valid_i = 1'b0;
        bus.res_ready_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        next();
        settle();
        check("t8_post_err", err, 0);
        check("t8_post_valid", bus.flt_valid_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
